// File: rtl/tap_pkg.sv
// Shared types and constants for the tap debounce counter.
package tap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } tap_state_e;

  localparam int MAX_COUNT = 99;
  localparam int TIMES_W   = 7;
  localparam int BCD_W     = 4;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(9)) ? '0 : d + BCD_W'(1);
  endfunction

endpackage

// File: rtl/tap_debounce.sv
// Synchronises the raw button and debounces it; press_stb pulses one cycle on each accepted press,
// DEBOUNCE_CYCLES+2 edges after tap first goes active. Free-running, no backpressure.
module tap_debounce
  import tap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter bit TAP_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tap,
  output logic press_stb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  tap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             tap_act;
  logic             stable_done;

  assign sync_d  = {sync_q[0], tap};
  assign tap_act = sync_q[1] ^ TAP_ACTIVE_LOW;

  // The entry edge is the first stable sample, so the counter runs to DEBOUNCE_CYCLES-2.
  assign stable_done = (int'(cnt_q) + 2) >= DEBOUNCE_CYCLES;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tap_act) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!tap_act) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!tap_act) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (tap_act) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {2{TAP_ACTIVE_LOW}};
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_stb = press_q;

endmodule

// File: rtl/tap_debounce_counter.sv
// Counts debounced presses 0..99 with press/wrap strobes, DEBOUNCE_CYCLES+3 edges after tap goes active.
// Free-running, no backpressure. Define TAP_BCD_OUT_EN to add incrementally kept tens/ones digits.
module tap_debounce_counter
  import tap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter bit TAP_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tap,
  output logic [TIMES_W-1:0] times,
  output logic               press_pulse,
  output logic               wrap_pulse
`ifdef TAP_BCD_OUT_EN
  ,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones
`endif
);

  logic               press_stb;
  logic               at_max;
  logic [TIMES_W-1:0] times_q, times_d;
  logic               press_pulse_q, press_pulse_d;
  logic               wrap_pulse_q, wrap_pulse_d;

  tap_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .TAP_ACTIVE_LOW (TAP_ACTIVE_LOW)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .tap      (tap),
    .press_stb(press_stb)
  );

  assign at_max = (times_q == TIMES_W'(MAX_COUNT));

  always_comb begin
    times_d       = times_q;
    press_pulse_d = press_stb;
    wrap_pulse_d  = press_stb & at_max;
    if (press_stb) begin
      times_d = at_max ? '0 : times_q + TIMES_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      times_q       <= '0;
      press_pulse_q <= 1'b0;
      wrap_pulse_q  <= 1'b0;
    end else begin
      times_q       <= times_d;
      press_pulse_q <= press_pulse_d;
      wrap_pulse_q  <= wrap_pulse_d;
    end
  end

  assign times       = times_q;
  assign press_pulse = press_pulse_q;
  assign wrap_pulse  = wrap_pulse_q;

`ifdef TAP_BCD_OUT_EN
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;

  // Digits track times in lockstep; 9/9 rolls both digits to 0/0 naturally.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (press_stb) begin
      ones_d = bcd_inc(ones_q);
      if (ones_q == BCD_W'(9)) begin
        tens_d = bcd_inc(tens_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
`endif

endmodule

// File: tb/tb_tap_debounce_counter.sv
// Bench for tap_debounce_counter with DEBOUNCE_CYCLES=4, active-low tap; digit checks follow TAP_BCD_OUT_EN.
module tb_tap_debounce_counter;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct {
    logic tap;
    int   cycles;
    bit   press;
    int   times;
  } vec_t;

  typedef struct {
    int cyc;
    int times;
    bit wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tap;
  logic [6:0] times;
  logic       press_pulse;
  logic       wrap_pulse;
`ifdef TAP_BCD_OUT_EN
  logic [3:0] tens;
  logic [3:0] ones;
`endif

  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   model_times = 0;
  int   wrap_cnt    = 0;
  exp_t sb[$];
  vec_t vecs[13];

  tap_debounce_counter #(
    .DEBOUNCE_CYCLES(DEB),
    .TAP_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tap        (tap),
    .times      (times),
    .press_pulse(press_pulse),
    .wrap_pulse (wrap_pulse)
`ifdef TAP_BCD_OUT_EN
    ,
    .tens       (tens),
    .ones       (ones)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

`ifdef TAP_BCD_OUT_EN
  task automatic check_digits(input string name, input int val);
    check({name, "_tens"}, int'(tens), val / 10);
    check({name, "_ones"}, int'(ones), val % 10);
  endtask
`endif

  // One clock: observe outputs on the falling edge, then land just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (press_pulse) begin
        if (sb.size() == 0) begin
          check("spurious_press", int'(press_pulse), 0);
        end else begin
          e = sb.pop_front();
          check("press_cycle", cyc, e.cyc);
          check("press_times", int'(times), e.times);
          check("press_wrap", int'(wrap_pulse), int'(e.wrap));
`ifdef TAP_BCD_OUT_EN
          check_digits("press", e.times);
`endif
          model_times = e.times;
          if (wrap_pulse) wrap_cnt++;
        end
      end else begin
        check("times_hold", int'(times), model_times);
        check("wrap_idle", int'(wrap_pulse), 0);
`ifdef TAP_BCD_OUT_EN
        check_digits("hold", model_times);
`endif
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply(input logic v, input int n, input bit press, input int t);
    tap = v;
    if (press) sb.push_back('{cyc + LAT, t, (t == 0)});
    repeat (n) step();
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b0;
    sb.delete();
    model_times = 0;
    #1;
    check("rst_times", int'(times), 0);
    check("rst_press", int'(press_pulse), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
`ifdef TAP_BCD_OUT_EN
    check_digits("rst", 0);
`endif
    repeat (n) step();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5,  1'b0, 0};
    vecs[1]  = '{1'b0, 20, 1'b1, 1};
    vecs[2]  = '{1'b1, 3,  1'b0, 0};
    vecs[3]  = '{1'b0, 10, 1'b0, 0};
    vecs[4]  = '{1'b1, 5,  1'b0, 0};
    vecs[5]  = '{1'b0, 10, 1'b1, 2};
    vecs[6]  = '{1'b1, 8,  1'b0, 0};
    vecs[7]  = '{1'b0, 3,  1'b0, 0};
    vecs[8]  = '{1'b1, 8,  1'b0, 0};
    vecs[9]  = '{1'b0, 4,  1'b1, 3};
    vecs[10] = '{1'b1, 4,  1'b0, 0};
    vecs[11] = '{1'b0, 8,  1'b1, 4};
    vecs[12] = '{1'b1, 8,  1'b0, 0};

    rst = 1'b0;
    tap = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    reset_dut(3);

    // Bouncing input shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 2, 1'b0, 0);
      apply(1'b1, 2, 1'b0, 0);
    end
    apply(1'b1, 10, 1'b0, 0);
    check("toggle_times", int'(times), 0);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].tap, vecs[i].cycles, vecs[i].press, vecs[i].times);
    end
    check("table_final_times", int'(times), 4);

    // Reset three cycles into a press; the still-held press counts once after release.
    apply(1'b0, 3, 1'b0, 0);
    reset_dut(3);
    apply(1'b0, 12, 1'b1, 1);
    check("rst_press_times", int'(times), 1);
    apply(1'b1, 8, 1'b0, 0);

    reset_dut(2);
    wrap_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 100) begin
        check("times_99", int'(times), 99);
`ifdef TAP_BCD_OUT_EN
        check_digits("pre_wrap", 99);
`endif
      end
      apply(1'b0, 6, 1'b1, i % 100);
      apply(1'b1, 6, 1'b0, 0);
    end
    check("wrap_once", wrap_cnt, 1);
    check("times_after_wrap", int'(times), 0);

    apply(1'b1, 10, 1'b0, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_debounce_counter.md
TAP_DEBOUNCE_COUNTER -- requirements
Module: tap_debounce_counter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 240000, giving the stable-input cycles needed to accept a level change (20 ms at 12 MHz).
REQ-002 The block SHALL have parameter TAP_ACTIVE_LOW, default 1; when 1, tap=0 means pressed.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port tap, input, 1 bit, raw asynchronous push-button level.
REQ-006 The block SHALL have port times, output, 7 bits, accepted-press count, binary, 0..99.
REQ-007 The block SHALL have port press_pulse, output, 1 bit, one-cycle strobe on each accepted press.
REQ-008 The block SHALL have port wrap_pulse, output, 1 bit, one-cycle strobe when times wraps 99->0.

Function
REQ-009 tap SHALL pass through a 2-flop synchronizer before any other use; the polarity is normalised to active-high after synchronisation.
REQ-010 The debouncer SHALL be a 4-state FSM: IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 IDLE->PRESS_WAIT on synced active; PRESS_WAIT->IDLE on synced inactive, with the stability counter cleared.
REQ-012 PRESS_WAIT->PRESSED once synced active has held DEBOUNCE_CYCLES consecutive cycles.
REQ-013 PRESSED->RELEASE_WAIT on synced inactive; RELEASE_WAIT->PRESSED on synced active, with the counter cleared.
REQ-014 RELEASE_WAIT->IDLE once synced inactive has held DEBOUNCE_CYCLES consecutive cycles.
REQ-015 The stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and cleared on every state entry.
REQ-016 On the PRESS_WAIT->PRESSED edge, times SHALL increment and press_pulse SHALL be high for exactly that following cycle.
REQ-017 Latency SHALL be exactly DEBOUNCE_CYCLES+3 clk edges from the first edge sampling tap active to the times update, with tap held stable.
REQ-018 At times=99 an accepted press SHALL set times=0 and assert wrap_pulse together with press_pulse.
REQ-019 A holding press SHALL count once only; the next count requires passing through IDLE.
REQ-020 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no count and no pulse.
REQ-021 times SHALL never exceed 99.

Reset
REQ-022 While rst=0, the FSM SHALL be IDLE, the synchronizer SHALL hold the inactive level, and counter, times, press_pulse and wrap_pulse SHALL be 0, asynchronously.
REQ-023 Reset mid-debounce or mid-press SHALL discard progress; a press still held after rst releases SHALL count once after a full DEBOUNCE_CYCLES.

Configuration
REQ-024 With TAP_BCD_OUT_EN defined, the block SHALL add outputs tens[3:0] and ones[3:0], which are 0 after reset and updated incrementally in the same cycle as times, with ones 9->0 carrying into tens, and 99 wrapping to 0/0; no divider is used.
REQ-025 Without TAP_BCD_OUT_EN, tens, ones and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 The FSM state enum, the MAX_COUNT=99 constant and the BCD digit width constant SHALL live in shared package tap_pkg.
REQ-027 The synchronizer-plus-debounce FSM SHALL be sub-module tap_debounce, emitting a one-cycle press strobe; the counter and wrap/BCD logic stay in the top level.

Verification (DEBOUNCE_CYCLES=4, TAP_ACTIVE_LOW=1)
REQ-028 Hold tap=0 for 20 cycles from reset: times 0->1 on edge 7 and stays 1; press_pulse high exactly 1 cycle.
REQ-029 Toggle tap 0/1 every 2 cycles for 40 cycles, then hold tap=1: times stays 0 and press_pulse never asserts.
REQ-030 Issue 100 clean presses: times reaches 99, then 0; wrap_pulse is high once, coincident with the 100th press_pulse; with TAP_BCD_OUT_EN, tens/ones read 9/9 then 0/0.
REQ-031 Drop rst to 0 after 3 active cycles of a press, release rst with tap still 0: times=0 during reset, then becomes 1 exactly 7 edges after release.
REQ-032 Press, then release for 3 cycles (a glitch), then press again: no second count; a 5-cycle release followed by a press gives times=2.
